// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared FSM state encoding for the ROM burst streamer
package rom_stream_pkg;
  typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/rom_stream.sv
// rom_stream: streams a burst of words from an external async ROM over a valid/ready port
module rom_stream
  import rom_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base,
  input  logic [ADDRW:0]   len,
  output logic [ADDRW-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  state_t         state;
  logic [ADDRW:0] rem;
  logic           xfer;
  logic           load;
  assign xfer = out_valid & out_ready;
  assign load = (state == STREAM) && (rem != '0) && (!out_valid || out_ready);
  // burst FSM: rom_addr is the pointer register, output word is refilled whenever it is empty or being taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= '0;
      rem       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && len != '0) begin
          rom_addr <= base;
          rem      <= len;
          busy     <= 1'b1;
          state    <= STREAM;
        end else if (start) begin
          done <= 1'b1;
        end
      end else begin
        if (load) begin
          out_data  <= rom_data;
          out_valid <= 1'b1;
          out_last  <= (rem == 1);
          rom_addr  <= (rom_addr == ADDRW'(DEPTH - 1)) ? '0 : rom_addr + 1'b1;
          rem       <= rem - 1'b1;
        end else if (xfer) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
        if (xfer && out_last) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rom_stream.sv
// tb_rom_stream: directed checks of rom_stream against a 16-word ROM holding 8'hA0+i
module tb_rom_stream;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] base = '0;
  logic [4:0] len = '0;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       busy;
  logic       done;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] q[$];

  rom_stream #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  assign rom_data = 8'hA0 + {4'b0, rom_addr};

  always #5 clk = ~clk;

  // record every word that will be accepted at the coming rising edge
  always @(negedge clk) if (!rst && out_valid && out_ready) q.push_back({out_last, out_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full-throughput burst; returns in the cycle where done is visible
  task automatic run_burst(input logic [3:0] b, input logic [4:0] n);
    q.delete();
    out_ready = 1'b1;
    base = b;
    len = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("addr_first", rom_addr, b);
    chk("busy_start", busy, 1);
    chk("valid_start", out_valid, 0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("word_valid", out_valid, 1);
      chk("word_data", out_data, 8'hA0 + ((b + i) % 16));
      chk("word_last", out_last, i == n - 1);
      chk("word_addr", rom_addr, (b + i + 1) % 16);
      chk("word_busy", busy, 1);
    end
    tick();
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    chk("valid_end", out_valid, 0);
    chk("word_count", q.size(), n);
  endtask

  logic [7:0] pd;
  logic       pl;
  logic [3:0] pa;
  logic       pv;
  logic       pr;
  logic       pat[6] = '{0, 0, 1, 0, 1, 1};

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_data", out_data, 0);

    run_burst(4'd3, 5'd4);
    tick();
    chk("done_one_cycle", done, 0);

    run_burst(4'd14, 5'd4);
    base = 4'd9;
    len = 5'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_on_done_busy", busy, 1);
    chk("start_on_done_addr", rom_addr, 9);
    tick();
    chk("start_on_done_word", out_data, 8'hA9);
    chk("start_on_done_last", out_last, 1);
    tick();
    chk("start_on_done_fin", done, 1);
    tick();

    base = 4'd0;
    len = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_valid", out_valid, 0);
    tick();
    chk("len0_done_drop", done, 0);
    chk("len0_valid2", out_valid, 0);
    chk("len0_busy2", busy, 0);

    q.delete();
    base = 4'd0;
    len = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      out_ready = pat[k];
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pl = out_last;
      pa = rom_addr;
      tick();
      if (pv && !pr) begin
        chk("bp_data_hold", out_data, pd);
        chk("bp_last_hold", out_last, pl);
        chk("bp_addr_hold", rom_addr, pa);
        chk("bp_valid_hold", out_valid, 1);
      end
    end
    chk("bp_done", done, 1);
    chk("bp_count", q.size(), 3);
    for (int i = 0; i < 3 && i < q.size(); i++) chk("bp_word", q[i], {i == 2, 8'hA0 + 8'(i)});
    out_ready = 1'b1;
    tick();

    base = 4'd0;
    len = 5'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_word2", out_data, 8'hA2);
    base = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_ignored_data", out_data, 8'hA3);
    chk("mid_ignored_addr", rom_addr, 4);
    tick();
    chk("mid_word4", out_data, 8'hA4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_done", done, 0);
    run_burst(4'd2, 5'd1);
    tick();

    run_burst(4'd0, 5'd20);
    tick();
    chk("long_idle_valid", out_valid, 0);
    chk("long_idle_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_stream.md
ROM_STREAM -- requirements
Module: rom_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256: ROM word count, any value >= 2.
REQ-003 SHALL have localparam ADDRW = $clog2(DEPTH): ROM address width.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: request a burst; sampled only in IDLE.
REQ-007 SHALL have port base, input, ADDRW: first ROM address of the burst, sampled with start.
REQ-008 SHALL have port len, input, ADDRW+1: word count of the burst, sampled with start; 0 is legal.
REQ-009 SHALL have port rom_addr, output, ADDRW: address to an asynchronous (zero-latency) ROM.
REQ-010 SHALL have port rom_data, input, WIDTH: ROM read data for rom_addr, valid in the same cycle.
REQ-011 SHALL have port out_data, output, WIDTH: streamed word.
REQ-012 SHALL have port out_valid, output, 1: out_data holds a word.
REQ-013 SHALL have port out_ready, input, 1: the consumer accepts the word this cycle.
REQ-014 SHALL have port out_last, output, 1: marks the final word of a burst; qualified by out_valid.
REQ-015 SHALL have port busy, output, 1: a burst is in progress.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at the end of a burst.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and STREAM.
REQ-018 IDLE with start=1 and len!=0 SHALL load the pointer with base and the remaining count with len, then enter STREAM with busy=1 from the next cycle.
REQ-019 IDLE with start=1 and len=0 SHALL stay in IDLE, emit no word, and pulse done for exactly one cycle, the cycle after start.
REQ-020 start while busy=1 SHALL be ignored, with no effect on the burst in progress.
REQ-021 rom_addr SHALL be driven directly from the pointer register (no combinational path from inputs).
REQ-022 Output register: it SHALL load rom_data, set out_valid and advance the pointer when in STREAM with remaining>0 and (out_valid=0 or out_ready=1).
REQ-023 Latency: with start sampled at rising edge E0, out_valid SHALL rise after E1 with out_data = mem[base].
REQ-024 Throughput: with out_ready held at 1, one word SHALL be emitted per cycle with no bubbles.
REQ-025 Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and rom_addr SHALL hold stable.
REQ-026 A transfer SHALL occur on each cycle with out_valid and out_ready both 1; out_valid SHALL fall after the transfer only if no next word is loaded.
REQ-027 The pointer SHALL increment by 1 per loaded word and wrap from DEPTH-1 to 0, also for non-power-of-two DEPTH.
REQ-028 Long bursts: len > DEPTH SHALL be legal; the burst re-reads through the wrap and emits exactly len words.
REQ-029 out_last SHALL be 1 only with the word loaded when remaining=1.
REQ-030 On the transfer of the out_last word, the block SHALL go to IDLE, drop busy next cycle and pulse done for one cycle, coincident with busy falling.
REQ-031 A start in the same cycle that done pulses SHALL be accepted, because the FSM is then in IDLE.
REQ-032 The remaining count SHALL use ADDRW+1 bits and never underflow.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE, abandon any burst in progress, and clear: out_valid, out_last, busy, done, out_data, rom_addr, remaining count.
REQ-034 Reset SHALL take priority over start and over any transfer in the same cycle.

Structure
REQ-035 The state enum (IDLE, STREAM) SHALL live in package rom_stream_pkg; all other constants SHALL stay local to the module.
REQ-036 The block SHALL contain no sub-modules; the ROM is external and connects via rom_addr and rom_data.

Verification (DEPTH=16, WIDTH=8, external async ROM initialised with mem[i]=8'hA0+i)
REQ-037 Start burst, out_ready=1 -> words A3,A4,A5,A6 on consecutive cycles starting E0+1, with:
- base=3, len=4
- out_last on A6
- done pulse 1 cycle after the A6 transfer
REQ-038 Wrap burst: base=14, len=4 -> A14,A15,A0,A1 and rom_addr sequence 14,15,0,1.
REQ-039 Backpressure: base=0, len=3, out_ready toggled 0,0,1,0,1,1 -> each word held stable while stalled; A0,A1,A2 delivered exactly once, in order.
REQ-040 len=0 -> no out_valid; done high exactly one cycle; busy stays 0.
REQ-041 Mid-burst control: during base=0, len=8
- start with base=5 at word 2 -> ignored
- rst at word 4 -> next cycle out_valid=0, busy=0, rom_addr=0; a new burst (base=2, len=1) -> a single word A2 with out_last
REQ-042 len=20 (> DEPTH) -> exactly 20 words A0..A15, A0..A3; out_last on the 20th word.
